// File: rtl/trap_vector_csrs_pkg.sv
// Shared configuration record, CSR addresses and trap-vector mode encodings
// for the trap CSR slice.
package trap_vector_csrs_pkg;

    typedef struct packed {
        int          XLEN;
        bit          COMPRESSED_SUPPORTED;
        bit          S_SUPPORTED;
        bit          H_SUPPORTED;
        logic [63:0] RESET_VECTOR;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{
        XLEN:                 64,
        COMPRESSED_SUPPORTED: 1'b1,
        S_SUPPORTED:          1'b1,
        H_SUPPORTED:          1'b0,
        RESET_VECTOR:         64'h0000_0000_8000_0000
    };

    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;
    localparam logic [11:0] MTVAL   = 12'h343;
    localparam logic [11:0] STVEC   = 12'h105;
    localparam logic [11:0] SEPC    = 12'h141;
    localparam logic [11:0] SCAUSE  = 12'h142;
    localparam logic [11:0] STVAL   = 12'h143;
    localparam logic [11:0] VSTVEC  = 12'h205;
    localparam logic [11:0] VSEPC   = 12'h241;
    localparam logic [11:0] VSCAUSE = 12'h242;
    localparam logic [11:0] VSTVAL  = 12'h243;

    localparam logic [1:0] DIRECT   = 2'b00;
    localparam logic [1:0] VECTORED = 2'b01;

endpackage

// File: rtl/trap_vector_csrs_if.sv
// Signal bundle between the trap-detection stage / CSR file and the trap CSR block.
interface trap_vector_csrs_if
    import trap_vector_csrs_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
);
    logic              StallW;
    logic              TrapM;
    logic              InterruptM;
    logic [3:0]        CauseM;
    logic              TrapToM;
    logic              TrapToHS;
    logic              TrapToVS;
    logic [P.XLEN-1:0] PCM;
    logic [P.XLEN-1:0] NextTvalM;
    logic              mretM;
    logic              sretM;
    logic              VirtModeW;
    logic              CSRWriteM;
    logic [11:0]       CSRAdrM;
    logic [P.XLEN-1:0] CSRWriteValM;
    logic [P.XLEN-1:0] CSRReadValM;
    logic              CSRHitM;
    logic [P.XLEN-1:0] TrapVectorM;
    logic [P.XLEN-1:0] RetPCM;
    logic              RedirectM;

    modport master (
        output StallW, TrapM, InterruptM, CauseM, TrapToM, TrapToHS, TrapToVS,
               PCM, NextTvalM, mretM, sretM, VirtModeW,
               CSRWriteM, CSRAdrM, CSRWriteValM,
        input  CSRReadValM, CSRHitM, TrapVectorM, RetPCM, RedirectM
    );

    modport slave (
        input  StallW, TrapM, InterruptM, CauseM, TrapToM, TrapToHS, TrapToVS,
               PCM, NextTvalM, mretM, sretM, VirtModeW,
               CSRWriteM, CSRAdrM, CSRWriteValM,
        output CSRReadValM, CSRHitM, TrapVectorM, RetPCM, RedirectM
    );
endinterface

// File: rtl/trap_vector_csrs_bank.sv
// One privilege level's xtvec/xepc/xcause/xtval with trap capture, WARL CSR
// writes, read decode and trap-vector generation.
module trap_csr_bank
    import trap_vector_csrs_pkg::*;
#(
    parameter cvw_t        P         = CVW_DEFAULT,
    parameter bit          PRESENT   = 1'b1,
    parameter logic [11:0] ADR_TVEC  = MTVEC,
    parameter logic [11:0] ADR_EPC   = MEPC,
    parameter logic [11:0] ADR_CAUSE = MCAUSE,
    parameter logic [11:0] ADR_TVAL  = MTVAL,
    parameter logic [63:0] TVEC_RST  = 64'd0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_capture,
    input  logic              i_csr_we,
    input  logic              i_interrupt,
    input  logic [3:0]        i_cause,
    input  logic [P.XLEN-1:0] i_pc,
    input  logic [P.XLEN-1:0] i_tval,
    input  logic [11:0]       i_adr,
    input  logic [P.XLEN-1:0] i_wdata,
    output logic [P.XLEN-1:0] o_rdata,
    output logic              o_hit,
    output logic [P.XLEN-1:0] o_epc,
    output logic [P.XLEN-1:0] o_vector
);
    localparam int XL = P.XLEN;
    localparam logic [XL-1:0] EPC_MASK  = P.COMPRESSED_SUPPORTED ? ~XL'(1) : ~XL'(3);
    localparam logic [XL-1:0] TVEC_MASK = ~XL'(2);

    logic [XL-1:0] r_tvec, r_epc, r_cause, r_tval;
    logic [XL-1:0] w_base;
    logic          w_we;

    assign w_we = i_en & PRESENT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tvec  <= TVEC_RST[XL-1:0] & ~XL'(3);
            r_epc   <= '0;
            r_cause <= '0;
            r_tval  <= '0;
        end else if (w_we) begin
            if (i_capture) begin
                r_epc   <= i_pc & EPC_MASK;
                r_cause <= {i_interrupt, {(XL-5){1'b0}}, i_cause};
                r_tval  <= i_interrupt ? '0 : i_tval;
            end else if (i_csr_we) begin
                if (i_adr == ADR_TVEC)  r_tvec  <= i_wdata & TVEC_MASK;
                if (i_adr == ADR_EPC)   r_epc   <= i_wdata & EPC_MASK;
                if (i_adr == ADR_CAUSE) r_cause <= i_wdata;
                if (i_adr == ADR_TVAL)  r_tval  <= i_wdata;
            end
        end
    end

    // A removed bank still decodes its addresses but reads back zero.
    assign o_hit = (i_adr == ADR_TVEC) | (i_adr == ADR_EPC) |
                   (i_adr == ADR_CAUSE) | (i_adr == ADR_TVAL);

    always_comb begin
        o_rdata = '0;
        if (PRESENT) begin
            case (i_adr)
                ADR_TVEC:  o_rdata = r_tvec;
                ADR_EPC:   o_rdata = r_epc;
                ADR_CAUSE: o_rdata = r_cause;
                ADR_TVAL:  o_rdata = r_tval;
                default:   o_rdata = '0;
            endcase
        end
    end

    assign w_base   = {r_tvec[XL-1:2], 2'b00};
    assign o_epc    = PRESENT ? r_epc : '0;
    assign o_vector = (r_tvec[1:0] == VECTORED && i_interrupt)
                    ? w_base + XL'({i_cause, 2'b00}) : w_base;

endmodule

// File: rtl/trap_vector_csrs.sv
// Trap CSR banks for M/HS/VS: bank routing, CSR read mux, trap vector and
// xRET return-PC selection for the fetch redirect.
module trap_vector_csrs
    import trap_vector_csrs_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
)(
    input  logic               clk,
    input  logic               reset,
    trap_vector_csrs_if.slave  bus
);
    localparam int XL = P.XLEN;

    logic          w_en, w_csr_we;
    logic          w_cap_m, w_cap_s, w_cap_vs;
    logic [XL-1:0] w_rd_m, w_rd_s, w_rd_vs;
    logic          w_hit_m, w_hit_s, w_hit_vs;
    logic [XL-1:0] w_epc_m, w_epc_s, w_epc_vs;
    logic [XL-1:0] w_vec_m, w_vec_s, w_vec_vs;

    assign w_en     = ~bus.StallW;
    // The trapping instruction's own CSR write never commits.
    assign w_csr_we = bus.CSRWriteM & ~bus.TrapM;
    assign w_cap_m  = bus.TrapM & bus.TrapToM;
    assign w_cap_s  = bus.TrapM & bus.TrapToHS;
    assign w_cap_vs = bus.TrapM & bus.TrapToVS;

    trap_csr_bank #(
        .P(P), .PRESENT(1'b1),
        .ADR_TVEC(MTVEC), .ADR_EPC(MEPC), .ADR_CAUSE(MCAUSE), .ADR_TVAL(MTVAL),
        .TVEC_RST(P.RESET_VECTOR)
    ) u_bank_m (
        .clk, .reset, .i_en(w_en), .i_capture(w_cap_m), .i_csr_we(w_csr_we),
        .i_interrupt(bus.InterruptM), .i_cause(bus.CauseM), .i_pc(bus.PCM),
        .i_tval(bus.NextTvalM), .i_adr(bus.CSRAdrM), .i_wdata(bus.CSRWriteValM),
        .o_rdata(w_rd_m), .o_hit(w_hit_m), .o_epc(w_epc_m), .o_vector(w_vec_m)
    );

    trap_csr_bank #(
        .P(P), .PRESENT(P.S_SUPPORTED),
        .ADR_TVEC(STVEC), .ADR_EPC(SEPC), .ADR_CAUSE(SCAUSE), .ADR_TVAL(STVAL),
        .TVEC_RST(64'd0)
    ) u_bank_s (
        .clk, .reset, .i_en(w_en), .i_capture(w_cap_s), .i_csr_we(w_csr_we),
        .i_interrupt(bus.InterruptM), .i_cause(bus.CauseM), .i_pc(bus.PCM),
        .i_tval(bus.NextTvalM), .i_adr(bus.CSRAdrM), .i_wdata(bus.CSRWriteValM),
        .o_rdata(w_rd_s), .o_hit(w_hit_s), .o_epc(w_epc_s), .o_vector(w_vec_s)
    );

    trap_csr_bank #(
        .P(P), .PRESENT(P.H_SUPPORTED),
        .ADR_TVEC(VSTVEC), .ADR_EPC(VSEPC), .ADR_CAUSE(VSCAUSE), .ADR_TVAL(VSTVAL),
        .TVEC_RST(64'd0)
    ) u_bank_vs (
        .clk, .reset, .i_en(w_en), .i_capture(w_cap_vs), .i_csr_we(w_csr_we),
        .i_interrupt(bus.InterruptM), .i_cause(bus.CauseM), .i_pc(bus.PCM),
        .i_tval(bus.NextTvalM), .i_adr(bus.CSRAdrM), .i_wdata(bus.CSRWriteValM),
        .o_rdata(w_rd_vs), .o_hit(w_hit_vs), .o_epc(w_epc_vs), .o_vector(w_vec_vs)
    );

    assign bus.CSRReadValM = w_rd_m | w_rd_s | w_rd_vs;
    assign bus.CSRHitM     = w_hit_m | w_hit_s | w_hit_vs;
    assign bus.RedirectM   = bus.TrapM | bus.mretM | bus.sretM;

    always_comb begin
        bus.TrapVectorM = w_vec_m;
        if (bus.TrapToHS)      bus.TrapVectorM = w_vec_s;
        else if (bus.TrapToVS) bus.TrapVectorM = w_vec_vs;
    end

    always_comb begin
        bus.RetPCM = w_epc_m;
        if (bus.sretM && !bus.mretM) bus.RetPCM = bus.VirtModeW ? w_epc_vs : w_epc_s;
    end

endmodule

// File: tb/tb_trap_vector_csrs.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// register-array reference model of the three trap CSR banks.
module tb_trap_vector_csrs;
    import trap_vector_csrs_pkg::*;

    localparam cvw_t P_A = '{XLEN: 64, COMPRESSED_SUPPORTED: 1'b1, S_SUPPORTED: 1'b1,
                             H_SUPPORTED: 1'b1, RESET_VECTOR: 64'h8000_0000};
    localparam cvw_t P_N = '{XLEN: 64, COMPRESSED_SUPPORTED: 1'b0, S_SUPPORTED: 1'b1,
                             H_SUPPORTED: 1'b0, RESET_VECTOR: 64'h8000_0000};

    logic clk, rst;
    int   total, bad;

    trap_vector_csrs_if #(.P(P_A)) ifc();
    trap_vector_csrs_if #(.P(P_N)) ifc2();

    trap_vector_csrs #(.P(P_A)) dut  (.clk(clk), .reset(rst), .bus(ifc));
    trap_vector_csrs #(.P(P_N)) dut2 (.clk(clk), .reset(rst), .bus(ifc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // index k: bank k/4 (0=M,1=HS,2=VS), register k%4 (tvec, epc, cause, tval)
    logic [11:0] adr_tbl [12] = '{12'h305, 12'h341, 12'h342, 12'h343,
                                  12'h105, 12'h141, 12'h142, 12'h143,
                                  12'h205, 12'h241, 12'h242, 12'h243};
    logic [63:0] m_reg [3][4];

    function automatic int find(input logic [11:0] a);
        for (int i = 0; i < 12; i++) if (adr_tbl[i] == a) return i;
        return -1;
    endfunction

    function automatic void model_update();
        int d, k;
        if (rst) begin
            for (int b = 0; b < 3; b++) for (int r = 0; r < 4; r++) m_reg[b][r] = 64'd0;
            m_reg[0][0] = 64'h8000_0000;
        end else if (!ifc.StallW) begin
            if (ifc.TrapM) begin
                d = ifc.TrapToM ? 0 : ifc.TrapToHS ? 1 : ifc.TrapToVS ? 2 : -1;
                if (d >= 0) begin
                    m_reg[d][1] = ifc.PCM & ~64'd1;
                    m_reg[d][2] = (ifc.InterruptM ? 64'h8000_0000_0000_0000 : 64'd0) + 64'(ifc.CauseM);
                    m_reg[d][3] = ifc.InterruptM ? 64'd0 : ifc.NextTvalM;
                end
            end else if (ifc.CSRWriteM) begin
                k = find(ifc.CSRAdrM);
                if (k >= 0) begin
                    case (k % 4)
                        0:       m_reg[k/4][0] = ifc.CSRWriteValM & ~64'd2;
                        1:       m_reg[k/4][1] = ifc.CSRWriteValM & ~64'd1;
                        default: m_reg[k/4][k%4] = ifc.CSRWriteValM;
                    endcase
                end
            end
        end
    endfunction

    function automatic logic [63:0] exp_vec(input int b, input logic intr, input logic [3:0] c);
        logic [63:0] base;
        base = m_reg[b][0] & ~64'd3;
        if (m_reg[b][0][0] && intr) return base + 64'(c) * 64'd4;
        return base;
    endfunction

    task automatic idle();
        ifc.StallW = 0; ifc.TrapM = 0; ifc.InterruptM = 0; ifc.CauseM = 0;
        ifc.TrapToM = 0; ifc.TrapToHS = 0; ifc.TrapToVS = 0;
        ifc.PCM = 0; ifc.NextTvalM = 0; ifc.mretM = 0; ifc.sretM = 0; ifc.VirtModeW = 0;
        ifc.CSRWriteM = 0; ifc.CSRAdrM = 0; ifc.CSRWriteValM = 0;
    endtask

    task automatic idle2();
        ifc2.StallW = 0; ifc2.TrapM = 0; ifc2.InterruptM = 0; ifc2.CauseM = 0;
        ifc2.TrapToM = 0; ifc2.TrapToHS = 0; ifc2.TrapToVS = 0;
        ifc2.PCM = 0; ifc2.NextTvalM = 0; ifc2.mretM = 0; ifc2.sretM = 0; ifc2.VirtModeW = 0;
        ifc2.CSRWriteM = 0; ifc2.CSRAdrM = 0; ifc2.CSRWriteValM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        idle();
        ifc.CSRWriteM = 1; ifc.CSRAdrM = a; ifc.CSRWriteValM = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [11:0] a, output logic [63:0] v);
        idle();
        ifc.CSRAdrM = a;
        #1 v = ifc.CSRReadValM;
        @(negedge clk);
    endtask

    task automatic wr2(input logic [11:0] a, input logic [63:0] d);
        idle2();
        ifc2.CSRWriteM = 1; ifc2.CSRAdrM = a; ifc2.CSRWriteValM = d;
        @(posedge clk); @(negedge clk);
        idle2();
    endtask

    task automatic rd2(input logic [11:0] a, output logic [63:0] v);
        idle2();
        ifc2.CSRAdrM = a;
        #1 v = ifc2.CSRReadValM;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [63:0] v;
        rd(12'h305, v);
        total++; if (v !== 64'h8000_0000) begin bad++; $display("FAIL reset_mtvec got=%h exp=%h", v, 64'h8000_0000); end
        for (int i = 1; i < 12; i++) begin
            if (i == 4 || i == 8) continue;
            rd(adr_tbl[i], v);
            total++; if (v !== 64'd0) begin bad++; $display("FAIL reset_reg_%h got=%h exp=0", adr_tbl[i], v); end
        end
        idle(); ifc.CSRAdrM = 12'h305;
        #1 total++; if (ifc.CSRHitM !== 1'b1) begin bad++; $display("FAIL hit_mtvec got=%b exp=1", ifc.CSRHitM); end
        ifc.CSRAdrM = 12'h300;
        #1 total++; if (ifc.CSRHitM !== 1'b0) begin bad++; $display("FAIL hit_300 got=%b exp=0", ifc.CSRHitM); end
        @(negedge clk);
    endtask

    task automatic test_vectored_interrupt();
        logic [63:0] v;
        wr(12'h305, 64'h8000_0103);
        rd(12'h305, v);
        total++; if (v !== 64'h8000_0101) begin bad++; $display("FAIL warl_mtvec_11 got=%h exp=%h", v, 64'h8000_0101); end
        wr(12'h305, 64'h8000_0102);
        rd(12'h305, v);
        total++; if (v !== 64'h8000_0100) begin bad++; $display("FAIL warl_mtvec_10 got=%h exp=%h", v, 64'h8000_0100); end
        wr(12'h305, 64'h8000_0101);
        idle();
        ifc.TrapM = 1; ifc.InterruptM = 1; ifc.TrapToM = 1; ifc.CauseM = 4'd7;
        ifc.PCM = 64'h1234; ifc.NextTvalM = 64'hBEEF;
        #1;
        total++; if (ifc.TrapVectorM !== 64'h8000_011C) begin bad++; $display("FAIL vec_irq7 got=%h exp=%h", ifc.TrapVectorM, 64'h8000_011C); end
        total++; if (ifc.RedirectM !== 1'b1) begin bad++; $display("FAIL redirect_trap got=%b exp=1", ifc.RedirectM); end
        tick();
        rd(12'h342, v);
        total++; if (v !== 64'h8000_0000_0000_0007) begin bad++; $display("FAIL mcause_irq got=%h exp=%h", v, 64'h8000_0000_0000_0007); end
        rd(12'h343, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL mtval_irq got=%h exp=0", v); end
        rd(12'h341, v);
        total++; if (v !== 64'h1234) begin bad++; $display("FAIL mepc_irq got=%h exp=%h", v, 64'h1234); end
    endtask

    task automatic test_exception_hs();
        logic [63:0] v;
        idle();
        ifc.TrapM = 1; ifc.TrapToHS = 1; ifc.CauseM = 4'd13;
        ifc.PCM = 64'h1002; ifc.NextTvalM = 64'hDEAD;
        tick();
        rd(12'h141, v);
        total++; if (v !== 64'h1002) begin bad++; $display("FAIL sepc got=%h exp=%h", v, 64'h1002); end
        rd(12'h142, v);
        total++; if (v !== 64'd13) begin bad++; $display("FAIL scause got=%h exp=%h", v, 64'd13); end
        rd(12'h143, v);
        total++; if (v !== 64'hDEAD) begin bad++; $display("FAIL stval got=%h exp=%h", v, 64'hDEAD); end
        rd(12'h341, v);
        total++; if (v !== 64'h1234) begin bad++; $display("FAIL mepc_untouched got=%h exp=%h", v, 64'h1234); end
        rd(12'h342, v);
        total++; if (v !== 64'h8000_0000_0000_0007) begin bad++; $display("FAIL mcause_untouched got=%h exp=%h", v, 64'h8000_0000_0000_0007); end
    endtask

    task automatic test_trap_over_write();
        logic [63:0] v;
        idle();
        ifc.CSRWriteM = 1; ifc.CSRAdrM = 12'h341; ifc.CSRWriteValM = 64'h40;
        ifc.TrapM = 1; ifc.TrapToM = 1; ifc.CauseM = 4'd2; ifc.PCM = 64'h2000; ifc.NextTvalM = 64'h77;
        tick();
        rd(12'h341, v);
        total++; if (v !== 64'h2000) begin bad++; $display("FAIL trap_beats_write got=%h exp=%h", v, 64'h2000); end
    endtask

    task automatic test_stall();
        logic [63:0] v;
        idle();
        ifc.StallW = 1; ifc.TrapM = 1; ifc.TrapToM = 1; ifc.InterruptM = 1; ifc.CauseM = 4'd9;
        ifc.PCM = 64'h5550;
        tick();
        idle();
        ifc.StallW = 1; ifc.CSRWriteM = 1; ifc.CSRAdrM = 12'h141; ifc.CSRWriteValM = 64'h999;
        tick();
        rd(12'h341, v);
        total++; if (v !== 64'h2000) begin bad++; $display("FAIL stall_mepc got=%h exp=%h", v, 64'h2000); end
        rd(12'h342, v);
        total++; if (v !== 64'd2) begin bad++; $display("FAIL stall_mcause got=%h exp=2", v); end
        rd(12'h343, v);
        total++; if (v !== 64'h77) begin bad++; $display("FAIL stall_mtval got=%h exp=%h", v, 64'h77); end
        rd(12'h141, v);
        total++; if (v !== 64'h1002) begin bad++; $display("FAIL stall_sepc got=%h exp=%h", v, 64'h1002); end
    endtask

    task automatic test_xret();
        wr(12'h241, 64'h3000);
        idle();
        ifc.sretM = 1; ifc.VirtModeW = 1;
        #1;
        total++; if (ifc.RetPCM !== 64'h3000) begin bad++; $display("FAIL sret_vs got=%h exp=%h", ifc.RetPCM, 64'h3000); end
        total++; if (ifc.RedirectM !== 1'b1) begin bad++; $display("FAIL redirect_sret got=%b exp=1", ifc.RedirectM); end
        ifc.VirtModeW = 0;
        #1 total++; if (ifc.RetPCM !== 64'h1002) begin bad++; $display("FAIL sret_hs got=%h exp=%h", ifc.RetPCM, 64'h1002); end
        ifc.mretM = 1;
        #1 total++; if (ifc.RetPCM !== 64'h2000) begin bad++; $display("FAIL mret_sret got=%h exp=%h", ifc.RetPCM, 64'h2000); end
        idle();
        #1 total++; if (ifc.RedirectM !== 1'b0) begin bad++; $display("FAIL redirect_idle got=%b exp=0", ifc.RedirectM); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [63:0] v;
        wr(12'h305, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h305, v);
        total++; if (v !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL warl_all_ones got=%h exp=%h", v, 64'hFFFF_FFFF_FFFF_FFFD); end
        idle();
        ifc.TrapM = 1; ifc.TrapToM = 1; ifc.InterruptM = 1; ifc.CauseM = 4'd15;
        #1 total++; if (ifc.TrapVectorM !== 64'h38) begin bad++; $display("FAIL vec_wrap got=%h exp=%h", ifc.TrapVectorM, 64'h38); end
        ifc.InterruptM = 0;
        #1 total++; if (ifc.TrapVectorM !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL vec_exc_base got=%h exp=%h", ifc.TrapVectorM, 64'hFFFF_FFFF_FFFF_FFFC); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_trap();
        logic [63:0] v;
        idle();
        rst = 1; ifc.TrapM = 1; ifc.TrapToM = 1; ifc.PCM = 64'h7770; ifc.NextTvalM = 64'h1;
        tick();
        rst = 0;
        idle();
        rd(12'h341, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL rst_mid_mepc got=%h exp=0", v); end
        rd(12'h305, v);
        total++; if (v !== 64'h8000_0000) begin bad++; $display("FAIL rst_mid_mtvec got=%h exp=%h", v, 64'h8000_0000); end
        rd(12'h241, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL rst_mid_vsepc got=%h exp=0", v); end
    endtask

    task automatic test_no_compressed();
        logic [63:0] v;
        wr2(12'h341, 64'h13);
        rd2(12'h341, v);
        total++; if (v !== 64'h10) begin bad++; $display("FAIL nc_mepc_write got=%h exp=%h", v, 64'h10); end
        idle2();
        ifc2.TrapM = 1; ifc2.TrapToM = 1; ifc2.CauseM = 4'd1; ifc2.PCM = 64'h1006;
        @(posedge clk); @(negedge clk);
        idle2();
        rd2(12'h341, v);
        total++; if (v !== 64'h1004) begin bad++; $display("FAIL nc_mepc_trap got=%h exp=%h", v, 64'h1004); end
        wr2(12'h241, 64'h44);
        rd2(12'h241, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL nc_vsepc_removed got=%h exp=0", v); end
        idle2();
        ifc2.TrapM = 1; ifc2.TrapToVS = 1; ifc2.CauseM = 4'd5; ifc2.PCM = 64'h2220; ifc2.NextTvalM = 64'h55;
        @(posedge clk); @(negedge clk);
        idle2();
        rd2(12'h243, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL nc_vstval_removed got=%h exp=0", v); end
        rd2(12'h341, v);
        total++; if (v !== 64'h1004) begin bad++; $display("FAIL nc_mepc_kept got=%h exp=%h", v, 64'h1004); end
    endtask

    task automatic test_random();
        logic [63:0] exp;
        int d, ai, k;
        for (int n = 0; n < 400; n++) begin
            idle();
            ifc.StallW = ($urandom_range(0, 3) == 0);
            ifc.TrapM  = ($urandom_range(0, 4) == 0);
            d = $urandom_range(0, 3);
            if (ifc.TrapM) begin
                ifc.TrapToM = (d == 0); ifc.TrapToHS = (d == 1); ifc.TrapToVS = (d == 2);
            end
            ifc.InterruptM = 1'($urandom_range(0, 1));
            ifc.CauseM     = 4'($urandom_range(0, 15));
            ifc.PCM        = {$urandom, $urandom};
            ifc.NextTvalM  = {$urandom, $urandom};
            ai = $urandom_range(0, 13);
            ifc.CSRAdrM    = (ai < 12) ? adr_tbl[ai] : ((ai == 12) ? 12'h300 : 12'h344);
            ifc.CSRWriteM  = !ifc.TrapM && ($urandom_range(0, 1) == 1);
            ifc.CSRWriteValM = {$urandom, $urandom};
            ifc.mretM      = ($urandom_range(0, 3) == 0);
            ifc.sretM      = ($urandom_range(0, 3) == 0);
            ifc.VirtModeW  = 1'($urandom_range(0, 1));
            #1;
            k = find(ifc.CSRAdrM);
            exp = (k >= 0) ? m_reg[k/4][k%4] : 64'd0;
            total++; if (ifc.CSRReadValM !== exp) begin bad++; $display("FAIL rand_read n=%0d adr=%h got=%h exp=%h", n, ifc.CSRAdrM, ifc.CSRReadValM, exp); end
            total++; if (ifc.CSRHitM !== (k >= 0)) begin bad++; $display("FAIL rand_hit n=%0d got=%b exp=%b", n, ifc.CSRHitM, (k >= 0)); end
            if (ifc.mretM)      exp = m_reg[0][1];
            else if (ifc.sretM) exp = ifc.VirtModeW ? m_reg[2][1] : m_reg[1][1];
            else                exp = m_reg[0][1];
            total++; if (ifc.RetPCM !== exp) begin bad++; $display("FAIL rand_retpc n=%0d got=%h exp=%h", n, ifc.RetPCM, exp); end
            total++; if (ifc.RedirectM !== (ifc.TrapM | ifc.mretM | ifc.sretM)) begin bad++; $display("FAIL rand_redirect n=%0d got=%b", n, ifc.RedirectM); end
            if (ifc.TrapM && d < 3) begin
                exp = exp_vec(d, ifc.InterruptM, ifc.CauseM);
                total++; if (ifc.TrapVectorM !== exp) begin bad++; $display("FAIL rand_vector n=%0d got=%h exp=%h", n, ifc.TrapVectorM, exp); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1;
        idle(); idle2();
        @(negedge clk);
        tick(); tick();
        rst = 0;
        test_reset();
        test_vectored_interrupt();
        test_exception_hs();
        test_trap_over_write();
        test_stall();
        test_xret();
        test_wrap();
        test_reset_mid_trap();
        test_no_compressed();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
